// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, instruction field layout and in-flight entry type for the ALU issue stage
package alu_pkg;

    localparam int RAW = 5;
    localparam int OPW = 6;

    localparam logic [OPW-1:0] OP_NOP = 6'b000000;
    localparam logic [OPW-1:0] OP_ADD = 6'b010000;
    localparam logic [OPW-1:0] OP_OR  = 6'b010001;
    localparam logic [OPW-1:0] OP_NOR = 6'b010010;
    localparam logic [OPW-1:0] OP_XOR = 6'b010011;
    localparam logic [OPW-1:0] OP_AND = 6'b010100;
    localparam logic [OPW-1:0] OP_RLS = 6'b001100;
    localparam logic [OPW-1:0] OP_LLS = 6'b001101;

    localparam int OP_LSB     = 26;
    localparam int RD_LSB     = 21;
    localparam int RA_LSB     = 16;
    localparam int RB_LSB     = 11;
    localparam int IMMSEL_BIT = 10;

    typedef struct packed {
        logic           valid;
        logic [RAW-1:0] rd;
    } inflight_t;

    function automatic logic is_legal_op(input logic [OPW-1:0] op);
        case (op)
            OP_ADD, OP_OR, OP_NOR, OP_XOR, OP_AND, OP_RLS, OP_LLS: is_legal_op = 1'b1;
            default:                                               is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - register file: two combinational read ports, one registered write port, r0 hardwired zero
module alu_regfile #(
    parameter int DW   = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [AW-1:0] ra_addr,
    output logic [DW-1:0] ra_data,
    input  logic [AW-1:0] rb_addr,
    output logic [DW-1:0] rb_data,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata
);

    logic [DW-1:0] regs [NREG];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign ra_data = (ra_addr == '0) ? '0 : regs[ra_addr];
    assign rb_data = (rb_addr == '0) ? '0 : regs[rb_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - decode/operand issue stage feeding a 2-cycle ALU, with RAW stall and ResultC forwarding
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DW   = 32,
    parameter int NREG = 32,
    parameter int IMMW = 10
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [31:0]    instr,
    input  logic [DW-1:0]  result_c,
    output logic [DW-1:0]  data_a,
    output logic [DW-1:0]  data_b,
    output logic [OPW-1:0] opcode,
    output logic           issue_valid,
    output logic           illegal_op
);

    logic [OPW-1:0]  op;
    logic [RAW-1:0]  rd, ra, rb;
    logic            imm_sel;
    logic [IMMW-1:0] imm;
    logic [DW-1:0]   imm_ext;
    logic [DW-1:0]   rf_a, rf_b;
    logic [DW-1:0]   opnd_a, opnd_b;
    inflight_t       s1, s2, s1_next;
    logic            ra_s1, rb_s1, ra_s2, rb_s2;
    logic            transfer, legal;

    assign op      = instr[OP_LSB +: OPW];
    assign rd      = instr[RD_LSB +: RAW];
    assign ra      = instr[RA_LSB +: RAW];
    assign rb      = instr[RB_LSB +: RAW];
    assign imm_sel = instr[IMMSEL_BIT];
    assign imm     = instr[IMMW-1:0];
    assign imm_ext = {{(DW-IMMW){imm[IMMW-1]}}, imm};

    // S1 result is not yet on ResultC, so a match there stalls; S2 result is, so it forwards.
    assign ra_s1 = (ra != '0) && s1.valid && (s1.rd == ra);
    assign rb_s1 = !imm_sel && (rb != '0) && s1.valid && (s1.rd == rb);
    assign ra_s2 = (ra != '0) && s2.valid && (s2.rd == ra);
    assign rb_s2 = !imm_sel && (rb != '0) && s2.valid && (s2.rd == rb);

    assign in_ready = !(ra_s1 || rb_s1);
    assign transfer = in_valid && in_ready;
    assign legal    = is_legal_op(op);

    assign opnd_a = ra_s2 ? result_c : rf_a;
    assign opnd_b = imm_sel ? imm_ext : (rb_s2 ? result_c : rf_b);

    always_comb begin
        s1_next       = '0;
        s1_next.valid = transfer && legal && (rd != '0);
        s1_next.rd    = rd;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1          <= '0;
            s2          <= '0;
            data_a      <= '0;
            data_b      <= '0;
            opcode      <= OP_NOP;
            issue_valid <= 1'b0;
            illegal_op  <= 1'b0;
        end else begin
            s2         <= s1;
            s1         <= s1_next;
            illegal_op <= transfer && !legal;
            if (transfer && legal) begin
                data_a      <= opnd_a;
                data_b      <= opnd_b;
                opcode      <= op;
                issue_valid <= 1'b1;
            end else begin
                opcode      <= OP_NOP;
                issue_valid <= 1'b0;
            end
        end
    end

    alu_regfile #(
        .DW   (DW),
        .NREG (NREG),
        .AW   (RAW)
    ) u_regfile (
        .clock   (clock),
        .reset_n (reset_n),
        .ra_addr (ra),
        .ra_data (rf_a),
        .rb_addr (rb),
        .rb_data (rf_b),
        .we      (s2.valid),
        .waddr   (s2.rd),
        .wdata   (result_c)
    );

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed self-checking bench for alu_issue_stage with a registered ALU model
module tb_alu_issue_stage;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] result_c;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [5:0]  opcode;
    logic        issue_valid;
    logic        illegal_op;

    int tests_run;
    int tests_failed;
    int stalls;

    localparam logic [5:0] ADD = 6'b010000;
    localparam logic [5:0] OR_ = 6'b010001;
    localparam logic [5:0] NOR = 6'b010010;
    localparam logic [5:0] XOR = 6'b010011;
    localparam logic [5:0] AND = 6'b010100;
    localparam logic [5:0] BAD = 6'b111111;

    alu_issue_stage dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .result_c    (result_c),
        .data_a      (data_a),
        .data_b      (data_b),
        .opcode      (opcode),
        .issue_valid (issue_valid),
        .illegal_op  (illegal_op)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result_c <= '0;
        end else begin
            case (opcode)
                6'b010000: result_c <= data_a + data_b;
                6'b010001: result_c <= data_a | data_b;
                6'b010010: result_c <= ~(data_a | data_b);
                6'b010011: result_c <= data_a ^ data_b;
                6'b010100: result_c <= data_a & data_b;
                6'b001100: result_c <= data_a >> data_b[4:0];
                6'b001101: result_c <= data_a << data_b[4:0];
                default:   result_c <= '0;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input int rd, input int ra,
                                       input int rb, input logic isel, input logic [9:0] imm);
        mk = {op, rd[4:0], ra[4:0], rb[4:0], isel, imm};
    endfunction

    task automatic send(input logic [31:0] ins, output int n);
        in_valid = 1'b1;
        instr    = ins;
        n        = 0;
        @(negedge clock);
        while (!in_ready && n < 8) begin
            n++;
            @(negedge clock);
        end
        check("in_ready_wait", {31'b0, in_ready}, 32'd1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        instr    = '0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        instr    = '0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
        in_valid     = 1'b0;
        instr        = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_data_a", data_a, 32'd0);
        check("rst_data_b", data_b, 32'd0);
        check("rst_opcode", {26'b0, opcode}, 32'd0);
        check("rst_issue_valid", {31'b0, issue_valid}, 32'd0);
        check("rst_illegal", {31'b0, illegal_op}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // preload r2=5 r3=7 r5=0x0F r6=0x3C through immediate adds
        send(mk(ADD, 2, 0, 0, 1'b1, 10'd5), stalls);
        check("ld_data_b", data_b, 32'd5);
        check("ld_opcode", {26'b0, opcode}, {26'b0, ADD});
        check("ld_issue_valid", {31'b0, issue_valid}, 32'd1);
        send(mk(ADD, 3, 0, 0, 1'b1, 10'd7), stalls);
        send(mk(ADD, 5, 0, 0, 1'b1, 10'h0F), stalls);
        send(mk(ADD, 6, 0, 0, 1'b1, 10'h3C), stalls);
        idle(3);

        // independent back-to-back
        send(mk(ADD, 1, 2, 3, 1'b0, 10'd0), stalls);
        check("ind_add_stalls", stalls, 32'd0);
        check("ind_add_a", data_a, 32'd5);
        check("ind_add_b", data_b, 32'd7);
        send(mk(XOR, 4, 5, 6, 1'b0, 10'd0), stalls);
        check("ind_xor_stalls", stalls, 32'd0);
        check("ind_xor_a", data_a, 32'h0F);
        check("ind_xor_b", data_b, 32'h3C);
        check("ind_xor_op", {26'b0, opcode}, {26'b0, XOR});
        idle(3);
        check("idle_opcode", {26'b0, opcode}, 32'd0);
        check("idle_issue_valid", {31'b0, issue_valid}, 32'd0);
        check("idle_hold_a", data_a, 32'h0F);
        send(mk(OR_, 10, 1, 0, 1'b0, 10'd0), stalls);
        check("wb_r1", data_a, 32'd12);
        send(mk(OR_, 11, 4, 0, 1'b0, 10'd0), stalls);
        check("wb_r4", data_a, 32'h33);
        idle(3);

        // RAW on the immediately previous instruction: stall then forward
        send(mk(ADD, 1, 2, 5, 1'b0, 10'd0), stalls);
        send(mk(OR_, 7, 1, 0, 1'b0, 10'd0), stalls);
        check("stall_count", stalls, 32'd1);
        check("stall_fwd_a", data_a, 32'd20);
        check("stall_or_op", {26'b0, opcode}, {26'b0, OR_});
        idle(3);

        // RAW two back: forward without stall
        send(mk(ADD, 1, 3, 6, 1'b0, 10'd0), stalls);
        send(mk(AND, 8, 2, 3, 1'b0, 10'd0), stalls);
        send(mk(NOR, 9, 1, 2, 1'b0, 10'd0), stalls);
        check("fwd_stalls", stalls, 32'd0);
        check("fwd_a", data_a, 32'h43);
        check("fwd_b", data_b, 32'd5);
        idle(3);
        send(mk(OR_, 12, 9, 0, 1'b0, 10'd0), stalls);
        check("wb_r9", data_a, 32'hFFFFFFB8);
        idle(3);

        // immediate: sign extension and Rb excluded from hazard check
        send(mk(ADD, 14, 2, 3, 1'b0, 10'd0), stalls);
        send(mk(ADD, 13, 2, 14, 1'b1, 10'h3FF), stalls);
        check("imm_stalls", stalls, 32'd0);
        check("imm_a", data_a, 32'd5);
        check("imm_b", data_b, 32'hFFFFFFFF);
        idle(3);

        // illegal opcode and Rd=0
        send(mk(BAD, 15, 2, 0, 1'b0, 10'd0), stalls);
        check("ill_pulse", {31'b0, illegal_op}, 32'd1);
        check("ill_opcode", {26'b0, opcode}, 32'd0);
        check("ill_issue_valid", {31'b0, issue_valid}, 32'd0);
        send(mk(OR_, 18, 15, 0, 1'b0, 10'd0), stalls);
        check("ill_no_hazard", stalls, 32'd0);
        check("ill_pulse_end", {31'b0, illegal_op}, 32'd0);
        check("ill_r15_zero", data_a, 32'd0);
        send(mk(ADD, 0, 2, 3, 1'b0, 10'd0), stalls);
        check("rd0_issue_valid", {31'b0, issue_valid}, 32'd1);
        check("rd0_a", data_a, 32'd5);
        idle(3);
        send(mk(OR_, 17, 0, 0, 1'b0, 10'd0), stalls);
        check("rd0_r0_zero", data_a, 32'd0);
        idle(2);

        // reset with a writeback still in flight
        send(mk(ADD, 20, 2, 3, 1'b0, 10'd0), stalls);
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("mid_rst_a", data_a, 32'd0);
        check("mid_rst_b", data_b, 32'd0);
        check("mid_rst_op", {26'b0, opcode}, 32'd0);
        check("mid_rst_valid", {31'b0, issue_valid}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("mid_rst_ready", {31'b0, in_ready}, 32'd1);
        send(mk(OR_, 21, 20, 2, 1'b0, 10'd0), stalls);
        check("mid_rst_stalls", stalls, 32'd0);
        check("mid_rst_r20", data_a, 32'd0);
        check("mid_rst_r2", data_b, 32'd0);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
